// File: rtl/mux_arb_pkg.sv
// Shared types for the 2:1 mux arbiter: output-stage state encoding and mux select constants.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic state_e hold_state(input logic idx);
        return (idx == SEL_B) ? HOLD1 : HOLD0;
    endfunction

endpackage

// File: rtl/mux_arb_2to1_rr_pick2.sv
// Combinational two-way round-robin winner pick with optional sticky lock.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any=0 when no eligible requester is valid.
module rr_pick2
    import mux_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic lock_vld,
    input  logic lock_idx,
    output logic winner,
    output logic any
);

    always_comb begin
        winner = SEL_A;
        any    = 1'b0;
        if (lock_vld) begin
            // a locked owner is the only eligible requester, even if idle
            winner = lock_idx;
            any    = (lock_idx == SEL_B) ? valid1 : valid0;
        end else if (valid0 && valid1) begin
            winner = ~last_grant;
            any    = 1'b1;
        end else if (valid0) begin
            winner = SEL_A;
            any    = 1'b1;
        end else if (valid1) begin
            winner = SEL_B;
            any    = 1'b1;
        end
    end

endmodule

// File: rtl/mux_arb_2to1.sv
// Round-robin arbiter steering two valid/ready requesters through a 2:1 mux into one output register (optional lock: MUX_ARB_LOCK_EN).
// Latency: 1 cycle from accepted input to out_valid; full throughput with simultaneous pop and load.
// Backpressure: out_ready=0 while holding freezes the output and drops both input readies.
module mux_arb_2to1
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic             in0_lock,
    input  logic             in1_lock,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               sel_q, sel_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic               lock_vld, lock_idx;
    logic               load_ok, winner, any, acc;
    logic [WIDTH-1:0]   win_data;

    rr_pick2 u_pick (
        .valid0     (in0_valid),
        .valid1     (in1_valid),
        .last_grant (last_grant_q),
        .lock_vld   (lock_vld),
        .lock_idx   (lock_idx),
        .winner     (winner),
        .any        (any)
    );

    always_comb begin
        load_ok   = (state_q == IDLE) || out_ready;
        in0_ready = !rst && load_ok && any && (winner == SEL_A);
        in1_ready = !rst && load_ok && any && (winner == SEL_B);
        acc       = (in0_valid && in0_ready) || (in1_valid && in1_ready);
        win_data  = (winner == SEL_B) ? in1_data : in0_data;
    end

`ifdef MUX_ARB_LOCK_EN
    logic lock_vld_q, lock_vld_d;
    logic lock_idx_q, lock_idx_d;

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_idx_d = lock_idx_q;
        // every accepted transfer re-decides the lock from the winner's lock bit
        if (acc) begin
            lock_vld_d = (winner == SEL_B) ? in1_lock : in0_lock;
            lock_idx_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q <= 1'b0;
            lock_idx_q <= SEL_A;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign lock_vld = lock_vld_q;
    assign lock_idx = lock_idx_q;
`else
    assign lock_vld = 1'b0;
    assign lock_idx = SEL_A;
`endif

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        xfer_cnt_d   = xfer_cnt_q;
        if (acc) begin
            out_data_d   = win_data;
            sel_d        = winner;
            state_d      = hold_state(winner);
            last_grant_d = winner;
            xfer_cnt_d   = (xfer_cnt_q == CNT_MAX) ? xfer_cnt_q : xfer_cnt_q + CNT_W'(1);
        end else if (state_q != IDLE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_data_q   <= '0;
            sel_q        <= SEL_A;
            last_grant_q <= SEL_B;
            xfer_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign out_valid = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Randomized and directed bench for mux_arb_2to1 against a transaction-level reference model.
module tb_mux_arb_2to1;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in0_valid = 1'b0, in1_valid = 1'b0;
    logic [WIDTH-1:0] in0_data = '0, in1_data = '0;
    logic             in0_ready, in1_ready;
    logic             in0_lock = 1'b0, in1_lock = 1'b0;
    logic             out_valid, out_ready = 1'b0, sel;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] xfer_cnt;

    int tests = 0;
    int fails = 0;

    // reference model: contents of the output slot and arbitration history
    logic             m_valid, m_sel, m_last, m_lockv, m_locki;
    logic [WIDTH-1:0] m_data;
    int               m_cnt;
    logic             e_r0, e_r1;

    always #5 clk = ~clk;

    mux_arb_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
`ifdef MUX_ARB_LOCK_EN
        .in0_lock  (in0_lock),
        .in1_lock  (in1_lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last = 1'b1;
        m_cnt = 0; m_lockv = 1'b0; m_locki = 1'b0;
    endtask

    // One clock: drive inputs, check readies, advance model, check registered outputs.
    task automatic cyc(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ordy,
                       input logic l0, input logic l1);
        logic ok0, ok1, room;
        @(negedge clk);
        rst = r; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1;
        out_ready = ordy; in0_lock = l0; in1_lock = l1;
        #1;
        room = !m_valid || ordy;
        if (m_lockv) begin
            ok0 = (m_locki == 1'b0) && v0;
            ok1 = (m_locki == 1'b1) && v1;
        end else if (v0 && v1) begin
            ok0 = (m_last == 1'b1);
            ok1 = (m_last == 1'b0);
        end else begin
            ok0 = v0;
            ok1 = v1;
        end
        e_r0 = !r && room && ok0;
        e_r1 = !r && room && ok1;
        chk("in0_ready", int'(in0_ready), int'(e_r0));
        chk("in1_ready", int'(in1_ready), int'(e_r1));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (e_r0 || e_r1) begin
            m_valid = 1'b1;
            m_sel   = e_r1;
            m_data  = e_r1 ? d1 : d0;
            m_last  = e_r1;
            m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
`ifdef MUX_ARB_LOCK_EN
            m_lockv = e_r1 ? l1 : l0;
            m_locki = e_r1;
`endif
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_data", int'(out_data), int'(m_data));
        chk("sel", int'(sel), int'(m_sel));
        chk("xfer_cnt", int'(xfer_cnt), m_cnt);
    endtask

    logic [7:0] exp_d [4];

    initial begin
        model_reset();
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;

        // reset held two cycles with both requesters valid
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
            chk("rst_ready0", int'(in0_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_cnt", int'(xfer_cnt), 0);
        end

        // contention: in0 first, then strict alternation
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
            if (i == 0) chk("first_in0_ready", int'(e_r0), 1);
            chk("cont_data", int'(out_data), int'(exp_d[i]));
            chk("cont_sel", int'(sel), i % 2);
        end

        // backpressure: hold 0x5A from in1, then pop and load in0 in the same cycle
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
            chk("bp_data", int'(out_data), 8'h5A);
            chk("bp_sel", int'(sel), 1);
            chk("bp_ready1", int'(in1_ready), 0);
        end
        cyc(1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("bp_reload", int'(out_data), 8'h33);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_valid", int'(out_valid), 0);

        // single requester streams without forced alternation
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("single_sel", int'(sel), 1);
        end
        chk("single_cnt", int'(xfer_cnt), 5);

        // saturation: 20 more transfers
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b1, 8'(i), 1'b1, 8'(i + 100), 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", int'(xfer_cnt), 15);

`ifdef MUX_ARB_LOCK_EN
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'(i), 1'b1, 8'hEE, 1'b1, (i < 3), 1'b0);
            chk("lock_sel", int'(sel), (i < 4) ? 0 : 1);
        end
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), 1'($urandom), 8'($urandom),
                1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
